// File: rtl/logic_reduce_pkg.sv
// Op encoding and per-bit reduction helpers shared by logic_reduce_pipe and its stages.
package logic_reduce_pkg;

  // Widest operand the identity helper can produce.
  localparam int LRP_MAX_W = 64;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } op_e;

  function automatic logic [LRP_MAX_W-1:0] identity(input op_e op, input int w);
    logic [LRP_MAX_W-1:0] ones;
    ones = {LRP_MAX_W{1'b1}} >> (LRP_MAX_W - w);
    case (op)
      OP_OR, OP_NOR, OP_XOR, OP_XNOR: identity = {LRP_MAX_W{1'b0}};
      default:                        identity = ones;
    endcase
  endfunction

  // Reserved codes fall into the default arm and reduce as AND.
  function automatic logic apply(input op_e op, input logic a, input logic b);
    case (op)
      OP_OR, OP_NOR:   apply = a | b;
      OP_XOR, OP_XNOR: apply = a ^ b;
      default:         apply = a & b;
    endcase
  endfunction

  function automatic logic is_inverting(input op_e op);
    case (op)
      OP_NAND, OP_NOR, OP_XNOR: is_inverting = 1'b1;
      default:                  is_inverting = 1'b0;
    endcase
  endfunction

  function automatic logic is_reserved(input op_e op);
    case (op)
      OP_RSV6, OP_RSV7: is_reserved = 1'b1;
      default:          is_reserved = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lrp_stage.sv
// One registered pairwise-reduction level: NI operands in, NI/2 results out, with
// valid/ready that lets the stage reload in the same cycle it hands its result on.
module lrp_stage
  import logic_reduce_pkg::*;
#(
  parameter int W    = 1,
  parameter int NI   = 2,
  parameter bit LAST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NI*W-1:0]     i_data,
  input  op_e                 i_op,
  input  logic                i_err,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [(NI/2)*W-1:0] o_data,
  output op_e                 o_op,
  output logic                o_err
);

  localparam int NO = NI / 2;

  logic            r_valid;
  logic [NO*W-1:0] r_data;
  op_e             r_op;
  logic            r_err;
  logic [NO*W-1:0] w_red;
  logic            w_adv;
  logic            w_load;
  logic            w_inv;

  assign w_adv   = r_valid & i_ready;
  assign o_ready = ~r_valid | w_adv;
  assign w_load  = i_valid & o_ready;
  // Only the last level inverts, so NAND/NOR/XNOR stay associative up the tree.
  assign w_inv   = LAST & is_inverting(i_op);

  // Pairwise reduction of adjacent operands, bit by bit.
  always_comb begin
    w_red = {(NO*W){1'b0}};
    for (int j = 0; j < NO; j++) begin
      for (int b = 0; b < W; b++) begin
        w_red[j*W+b] = apply(i_op, i_data[2*j*W+b], i_data[(2*j+1)*W+b]) ^ w_inv;
      end
    end
  end

  // Stage register: load on accept, empty when the result leaves without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= {(NO*W){1'b0}};
      r_op    <= OP_AND;
      r_err   <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= w_red;
      r_op    <= i_op;
      r_err   <= i_err;
    end else if (w_adv) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_op    = r_op;
  assign o_err   = r_err;

endmodule

// File: rtl/logic_reduce_pipe.sv
// N-input, W-bit pipelined bitwise reduction (AND/OR/XOR and inversions), one register per
// tree level. Define LRP_STATS_EN to add the saturating out_cnt completion counter.
module logic_reduce_pipe
  import logic_reduce_pkg::*;
#(
  parameter int N     = 3,
  parameter int W     = 1,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic [2:0]     in_op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_err
`ifdef LRP_STATS_EN
  ,
  output logic [CNT_W-1:0] out_cnt
`endif
);

  localparam int L   = $clog2(N);
  localparam int P   = 1 << L;
  // All tree levels packed back to back: leaves (P operands) first, final result last.
  localparam int TOT = (2 * P - 1) * W;

  logic [TOT-1:0] w_lvl;
  logic [W-1:0]   w_ident;
  op_e            w_in_op;
  logic           w_vld [0:L];
  logic           w_rdy [0:L];
  op_e            w_op  [0:L];
  logic           w_err [0:L];

  assign w_in_op  = op_e'(in_op);
  assign w_ident  = W'(identity(w_in_op, W));
  assign w_vld[0] = in_valid;
  assign w_op[0]  = w_in_op;
  assign w_err[0] = is_reserved(w_in_op);
  assign w_rdy[L] = out_ready;
  assign in_ready = w_rdy[0] & ~rst;

  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k < N) begin : g_operand
      assign w_lvl[k*W +: W] = in_data[k*W +: W];
    end else begin : g_pad
      assign w_lvl[k*W +: W] = w_ident;
    end
  end

  for (genvar s = 0; s < L; s++) begin : g_st
    localparam int NI = P >> s;
    localparam int OI = (2 * P - 2 * NI) * W;
    localparam int OO = (2 * P - NI) * W;

    lrp_stage #(
      .W    (W),
      .NI   (NI),
      .LAST (s == L - 1)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_vld[s]),
      .o_ready (w_rdy[s]),
      .i_data  (w_lvl[OI +: NI*W]),
      .i_op    (w_op[s]),
      .i_err   (w_err[s]),
      .o_valid (w_vld[s+1]),
      .i_ready (w_rdy[s+1]),
      .o_data  (w_lvl[OO +: (NI/2)*W]),
      .o_op    (w_op[s+1]),
      .o_err   (w_err[s+1])
    );
  end

  assign out_valid = w_vld[L];
  assign out_data  = w_lvl[TOT-1 -: W];
  assign out_err   = w_err[L];

`ifdef LRP_STATS_EN
  logic [CNT_W-1:0] r_cnt;

  // Completed-handshake counter that sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_cnt = r_cnt;
`endif

endmodule
